// File: rtl/bus_decoder_pkg.sv
// Shared constants and types for the CPU memory decoder: address map prefixes,
// error codes and FSM state encoding.
package bus_decoder_pkg;

   localparam int unsigned ADDR_W      = 32;
   localparam int unsigned DATA_W      = 32;
   localparam int unsigned STRB_W      = 4;
   localparam int unsigned MAX_TARGETS = 16;
   localparam int unsigned MIN_CNT_W   = 11;

   // MMIO cores decode on the top byte, memory areas on the top two bits.
   localparam logic [ADDR_W-1:0] MMIO_PREFIX   = 32'hc000_0000;
   localparam logic [ADDR_W-1:0] CORE_MASK     = 32'hff00_0000;
   localparam logic [ADDR_W-1:0] AREA_MASK     = 32'hc000_0000;
   localparam logic [ADDR_W-1:0] AREA_RAM_BASE = 32'h4000_0000;

   localparam logic [DATA_W-1:0] ILLEGAL_INSTRUCTION = 32'hffff_ffff;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_UNMAPPED = 2'd1,
      ERR_PROTECT  = 2'd2,
      ERR_TIMEOUT  = 2'd3
   } err_code_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   // Base address of MMIO core number idx.
   function automatic logic [ADDR_W-1:0] core_base(input int unsigned idx);
      return MMIO_PREFIX | (ADDR_W'(idx) << 24);
   endfunction

endpackage

// File: rtl/bus_decoder_if.sv
// picorv32-style native memory request/response bus between CPU and decoder.
interface bus_decoder_if;
   import bus_decoder_pkg::*;

   logic              cpu_valid;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [STRB_W-1:0] cpu_wstrb;
   logic              cpu_ready;
   logic [DATA_W-1:0] cpu_rdata;

   modport master (
      output cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
      input  cpu_ready, cpu_rdata
   );

   modport slave (
      input  cpu_valid, cpu_addr, cpu_wdata, cpu_wstrb,
      output cpu_ready, cpu_rdata
   );

endinterface

// File: rtl/bus_decoder_addr_match.sv
// Base/mask address compare across all targets with lowest-index priority.
// Purely combinational so it can be shared by other bridges.
module bus_decoder_addr_match
   import bus_decoder_pkg::*;
#(
   parameter int unsigned                NUM_TARGETS = 8,
   parameter logic [32*NUM_TARGETS-1:0]  TGT_BASE    = {NUM_TARGETS{32'h0}},
   parameter logic [32*NUM_TARGETS-1:0]  TGT_MASK    = {NUM_TARGETS{32'hffffffff}},
   localparam int unsigned               IDX_W       = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1
) (
   input  logic [ADDR_W-1:0]      addr,
   output logic [NUM_TARGETS-1:0] hit_onehot,
   output logic                   hit_any,
   output logic [IDX_W-1:0]       hit_idx
);

   // Walk from the top down so the lowest matching index is the one kept.
   always_comb begin
      hit_onehot = '0;
      hit_any    = 1'b0;
      hit_idx    = '0;
      for (int i = int'(NUM_TARGETS) - 1; i >= 0; i--) begin
         if ((addr & TGT_MASK[32*i +: 32]) == TGT_BASE[32*i +: 32]) begin
            hit_onehot    = '0;
            hit_onehot[i] = 1'b1;
            hit_any       = 1'b1;
            hit_idx       = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/bus_decoder.sv
// Routes one CPU memory request to one of NUM_TARGETS cores, with access
// timeout, system-mode protection and a latched error report.
module bus_decoder
   import bus_decoder_pkg::*;
#(
   parameter int unsigned               NUM_TARGETS    = 8,
   parameter logic [32*NUM_TARGETS-1:0] TGT_BASE       = {NUM_TARGETS{32'h0}},
   parameter logic [32*NUM_TARGETS-1:0] TGT_MASK       = {NUM_TARGETS{32'hffffffff}},
   parameter logic [NUM_TARGETS-1:0]    PROTECT        = '0,
   parameter int unsigned               TIMEOUT_CYCLES = 1023,
   parameter logic [DATA_W-1:0]         DEFAULT_DATA   = 32'h0,
   parameter logic [DATA_W-1:0]         TRAP_DATA      = 32'h0
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          system_mode,
   input  logic                          force_trap,
   bus_decoder_if.slave                  cpu,
   output logic [NUM_TARGETS-1:0]        tgt_cs,
   output logic                          tgt_we,
   output logic [STRB_W-1:0]             tgt_wstrb,
   output logic [ADDR_W-1:0]             tgt_addr,
   output logic [DATA_W-1:0]             tgt_wdata,
   input  logic [DATA_W*NUM_TARGETS-1:0] tgt_rdata,
   input  logic [NUM_TARGETS-1:0]        tgt_ready,
   output logic                          err_valid,
   output logic [1:0]                    err_code,
   output logic [ADDR_W-1:0]             err_addr
);

   localparam int unsigned IDX_W   = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
   localparam int unsigned CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned CNT_W   = (CNT_RAW > MIN_CNT_W) ? CNT_RAW : MIN_CNT_W;

   state_e              state;
   logic [IDX_W-1:0]    sel_idx;
   logic [CNT_W-1:0]    tmo_cnt;
   logic                ready_q;
   logic [DATA_W-1:0]   rdata_q;
   logic                err_valid_q;
   err_code_e           err_code_q;
   logic [ADDR_W-1:0]   err_addr_q;

   logic [NUM_TARGETS-1:0] match_onehot;
   logic                   match_any;
   logic [IDX_W-1:0]       match_idx;

   logic                cur_sel;
   logic [IDX_W-1:0]    cur_idx;
   logic                local_rsp;
   logic [DATA_W-1:0]   local_rdata;
   err_code_e           local_err;
   logic                sel_ready;
   logic [DATA_W-1:0]   sel_rdata;

   bus_decoder_addr_match #(
      .NUM_TARGETS (NUM_TARGETS),
      .TGT_BASE    (TGT_BASE),
      .TGT_MASK    (TGT_MASK)
   ) u_match (
      .addr       (cpu.cpu_addr),
      .hit_onehot (match_onehot),
      .hit_any    (match_any),
      .hit_idx    (match_idx)
   );

   assign tgt_we    = |cpu.cpu_wstrb;
   assign tgt_wstrb = cpu.cpu_wstrb;
   assign tgt_addr  = cpu.cpu_addr;
   assign tgt_wdata = cpu.cpu_wdata;

   assign cpu.cpu_ready = ready_q;
   assign cpu.cpu_rdata = rdata_q;
   assign err_valid     = err_valid_q;
   assign err_code      = err_code_q;
   assign err_addr      = err_addr_q;

   // Decode: a fresh request is decoded in IDLE; once a target holds cs it keeps it.
   always_comb begin
      cur_sel     = 1'b0;
      cur_idx     = sel_idx;
      local_rsp   = 1'b0;
      local_rdata = DEFAULT_DATA;
      local_err   = ERR_NONE;
      if (reset_n && cpu.cpu_valid) begin
         if (state == ST_IDLE) begin
            if (force_trap) begin
               local_rsp   = 1'b1;
               local_rdata = TRAP_DATA;
            end else if (!match_any) begin
               local_rsp = 1'b1;
               local_err = ERR_UNMAPPED;
            end else if ((|(match_onehot & PROTECT)) && !system_mode) begin
               local_rsp = 1'b1;
               local_err = ERR_PROTECT;
            end else begin
               cur_sel = 1'b1;
               cur_idx = match_idx;
            end
         end else if (state == ST_ACCESS) begin
            if ((TIMEOUT_CYCLES != 0) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES))) begin
               local_rsp = 1'b1;
               local_err = ERR_TIMEOUT;
            end else begin
               cur_sel = 1'b1;
            end
         end
      end
   end

   // Chip select and read-data/ready mux for the selected target.
   always_comb begin
      tgt_cs    = '0;
      sel_ready = 1'b0;
      sel_rdata = '0;
      for (int i = 0; i < int'(NUM_TARGETS); i++) begin
         if (cur_idx == IDX_W'(i)) begin
            tgt_cs[i] = cur_sel;
            sel_ready = tgt_ready[i];
            sel_rdata = tgt_rdata[DATA_W*i +: DATA_W];
         end
      end
   end

   // Access FSM with registered response and error report.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_IDLE;
         sel_idx     <= '0;
         tmo_cnt     <= '0;
         ready_q     <= 1'b0;
         rdata_q     <= '0;
         err_valid_q <= 1'b0;
         err_code_q  <= ERR_NONE;
         err_addr_q  <= '0;
      end else begin
         ready_q     <= 1'b0;
         err_valid_q <= 1'b0;
         case (state)
            ST_IDLE, ST_ACCESS: begin
               if (!cpu.cpu_valid) begin
                  state   <= ST_IDLE;
                  tmo_cnt <= '0;
               end else if (local_rsp) begin
                  state   <= ST_RESP;
                  tmo_cnt <= '0;
                  ready_q <= 1'b1;
                  rdata_q <= local_rdata;
                  if (local_err != ERR_NONE) begin
                     err_valid_q <= 1'b1;
                     err_code_q  <= local_err;
                     err_addr_q  <= cpu.cpu_addr;
                  end
               end else if (cur_sel && sel_ready) begin
                  state   <= ST_RESP;
                  tmo_cnt <= '0;
                  ready_q <= 1'b1;
                  rdata_q <= sel_rdata;
               end else begin
                  state   <= ST_ACCESS;
                  sel_idx <= cur_idx;
                  if (tmo_cnt != '1) tmo_cnt <= tmo_cnt + CNT_W'(1);
               end
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   a_cs_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(tgt_cs));

endmodule

// File: tb/tb_bus_decoder.sv
// Directed scoreboard bench for bus_decoder: driver pushes expected responses,
// a negedge monitor pops and compares them whenever cpu_ready is seen.
module tb_bus_decoder;
   import bus_decoder_pkg::*;

   localparam int unsigned N = 8;
   localparam logic [32*N-1:0] TB_BASE = {AREA_RAM_BASE, 32'hc600_0000, 32'hc500_0000,
      32'hc400_0000, 32'hc300_0000, 32'hc200_0000, 32'hc100_0000, 32'hc000_0000};
   localparam logic [32*N-1:0] TB_MASK = {AREA_MASK, {7{CORE_MASK}}};

   typedef struct {
      logic [31:0] rdata;
      logic        err_valid;
      logic [1:0]  err_code;
      logic [31:0] err_addr;
      logic [7:0]  cs;
      logic        we;
      int          cs_cycles;
      int          latency;
      int          issue;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          system_mode = 1'b0;
   logic          force_trap = 1'b0;
   logic [N-1:0]  tgt_cs;
   logic          tgt_we;
   logic [3:0]    tgt_wstrb;
   logic [31:0]   tgt_addr;
   logic [31:0]   tgt_wdata;
   logic [32*N-1:0] tgt_rdata;
   logic [N-1:0]  tgt_ready;
   logic          err_valid;
   logic [1:0]    err_code;
   logic [31:0]   err_addr;

   int   checks = 0;
   int   errors = 0;
   int   cycle = 0;
   int   cs_cycles = 0;
   logic [7:0] last_cs = '0;
   logic last_we = 1'b0;
   logic [3:0] w3 = '0;
   exp_t sb[$];

   bus_decoder_if bus();

   bus_decoder #(
      .NUM_TARGETS    (N),
      .TGT_BASE       (TB_BASE),
      .TGT_MASK       (TB_MASK),
      .PROTECT        (8'b0010_0000),
      .TIMEOUT_CYCLES (8),
      .DEFAULT_DATA   (32'h0),
      .TRAP_DATA      (ILLEGAL_INSTRUCTION)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .system_mode (system_mode),
      .force_trap  (force_trap),
      .cpu         (bus),
      .tgt_cs      (tgt_cs),
      .tgt_we      (tgt_we),
      .tgt_wstrb   (tgt_wstrb),
      .tgt_addr    (tgt_addr),
      .tgt_wdata   (tgt_wdata),
      .tgt_rdata   (tgt_rdata),
      .tgt_ready   (tgt_ready),
      .err_valid   (err_valid),
      .err_code    (err_code),
      .err_addr    (err_addr)
   );

   always #5 clk = ~clk;

   // Target models: 3 has three wait states, 4 never answers, the rest are zero-wait.
   assign tgt_ready = {3'b111, 1'b0, (w3 == 4'd3), 3'b111};
   initial for (int i = 0; i < int'(N); i++) tgt_rdata[32*i +: 32] = 32'hcafe_0000 | 32'(i);
   initial forever begin
      @(posedge clk);
      if (tgt_cs[3] && !tgt_ready[3]) w3 <= w3 + 4'd1;
      else w3 <= '0;
   end

   initial forever begin
      @(posedge clk);
      cycle = cycle + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] rdata, input logic ev, input logic [1:0] code,
                               input logic [31:0] eaddr, input logic [7:0] cs, input logic we,
                               input int csn, input int lat);
      exp_t e;
      e.rdata = rdata; e.err_valid = ev; e.err_code = code; e.err_addr = eaddr;
      e.cs = cs; e.we = we; e.cs_cycles = csn; e.latency = lat; e.issue = 0;
      return e;
   endfunction

   // Monitor: tracks chip-select activity and scores every response.
   initial forever begin
      exp_t e;
      @(negedge clk);
      if (!reset_n) begin
         cs_cycles = 0;
         last_cs   = '0;
         last_we   = 1'b0;
      end else begin
         if (tgt_cs != '0) begin
            cs_cycles++;
            last_cs = tgt_cs;
            last_we = tgt_we;
         end
         if (err_valid && !bus.cpu_ready) chk("err_valid_without_ready", 32'(err_valid), 32'd0);
         if (bus.cpu_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_ready", 32'(bus.cpu_ready), 32'd0);
            end else begin
               e = sb.pop_front();
               chk("rdata",     bus.cpu_rdata,    e.rdata);
               chk("err_valid", 32'(err_valid),   32'(e.err_valid));
               chk("err_code",  32'(err_code),    32'(e.err_code));
               chk("err_addr",  err_addr,         e.err_addr);
               chk("cs_value",  32'(last_cs),     32'(e.cs));
               chk("cs_we",     32'(last_we),     32'(e.we));
               chk("cs_cycles", 32'(cs_cycles),   32'(e.cs_cycles));
               chk("latency",   32'(cycle - e.issue), 32'(e.latency));
            end
            cs_cycles = 0;
            last_cs   = '0;
            last_we   = 1'b0;
         end
      end
   end

   task automatic access(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic sys, input logic trap, input exp_t e);
      bit got = 1'b0;
      @(posedge clk); #1;
      system_mode   = sys;
      force_trap    = trap;
      bus.cpu_addr  = addr;
      bus.cpu_wdata = wdata;
      bus.cpu_wstrb = wstrb;
      e.issue       = cycle;
      sb.push_back(e);
      bus.cpu_valid = 1'b1;
      for (int n = 0; n < 40 && !got; n++) begin
         @(negedge clk);
         if (bus.cpu_ready) got = 1'b1;
      end
      if (!got) chk("ready_timeout", 32'h0, 32'h1);
      @(posedge clk); #1;
      bus.cpu_valid = 1'b0;
      bus.cpu_wstrb = '0;
      force_trap    = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_cs"},        32'(tgt_cs),        32'h0);
      chk({tag, "_ready"},     32'(bus.cpu_ready), 32'h0);
      chk({tag, "_rdata"},     bus.cpu_rdata,      32'h0);
      chk({tag, "_err_valid"}, 32'(err_valid),     32'h0);
      chk({tag, "_err_code"},  32'(err_code),      32'h0);
      chk({tag, "_err_addr"},  err_addr,           32'h0);
   endtask

   initial begin
      bus.cpu_valid = 1'b0;
      bus.cpu_addr  = '0;
      bus.cpu_wdata = '0;
      bus.cpu_wstrb = '0;
      #3;
      check_reset_vals("por");
      repeat (2) @(posedge clk);
      #2 reset_n = 1'b1;

      access(32'hc200_0000, 32'h0, 4'h0, 1'b0, 1'b0, mk(32'hcafe_0002, 0, 2'd0, 32'h0, 8'h04, 0, 1, 1));
      access(32'hc300_0010, 32'h0, 4'h0, 1'b0, 1'b0, mk(32'hcafe_0003, 0, 2'd0, 32'h0, 8'h08, 0, 4, 4));
      access(32'hc400_0020, 32'h0, 4'h0, 1'b0, 1'b0, mk(32'h0, 1, 2'd3, 32'hc400_0020, 8'h10, 0, 8, 9));
      access(32'hc500_0000, 32'h1234_5678, 4'hf, 1'b0, 1'b0, mk(32'h0, 1, 2'd2, 32'hc500_0000, 8'h00, 0, 0, 1));
      access(32'hc500_0000, 32'h1234_5678, 4'hf, 1'b1, 1'b0, mk(32'hcafe_0005, 0, 2'd2, 32'hc500_0000, 8'h20, 1, 1, 1));
      access(32'h8000_0000, 32'h0, 4'h0, 1'b0, 1'b0, mk(32'h0, 1, 2'd1, 32'h8000_0000, 8'h00, 0, 0, 1));
      access(32'h8000_0000, 32'h0, 4'h0, 1'b0, 1'b1, mk(32'hffff_ffff, 0, 2'd1, 32'h8000_0000, 8'h00, 0, 0, 1));
      access(32'hc200_0000, 32'h0, 4'h0, 1'b1, 1'b1, mk(32'hffff_ffff, 0, 2'd1, 32'h8000_0000, 8'h00, 0, 0, 1));
      access(32'h4000_1234, 32'h0, 4'h0, 1'b0, 1'b0, mk(32'hcafe_0007, 0, 2'd1, 32'h8000_0000, 8'h80, 0, 1, 1));

      // Reset in the middle of a wait-state access, CPU still holding valid.
      @(posedge clk); #1;
      bus.cpu_addr  = 32'hc300_0000;
      bus.cpu_wstrb = 4'h0;
      bus.cpu_valid = 1'b1;
      repeat (2) begin @(posedge clk); #1; end
      chk("cs_before_reset", 32'(tgt_cs), 32'h08);
      reset_n = 1'b0;
      #1;
      check_reset_vals("mid_reset");
      repeat (2) @(posedge clk);
      #1 bus.cpu_valid = 1'b0;
      #2 reset_n = 1'b1;
      access(32'hc300_0000, 32'h0, 4'h0, 1'b0, 1'b0, mk(32'hcafe_0003, 0, 2'd0, 32'h0, 8'h08, 0, 4, 4));

      repeat (3) @(posedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
